macc_pipe_dump: RTL and testbench

Parametrised, pipelined multiply-accumulate unit for the qlf_k6n10f DSP flow. It generalises the simple MACC to configurable operand and accumulator widths, signed or unsigned arithmetic, and optional saturation. It adds a valid-qualified input stream, a pipeline stall, an accumulate-and-dump mode with a sample counter, and a sticky overflow flag. It serves as the inference and equivalence target for DSP MACC mapping with input, product and accumulator registers.

---
 rtl/macc_pipe_dump.sv | 172 +++++++++++++++++
 tb/tb_macc_pipe_dump.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_pipe_dump.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : macc_pipe_dump
//  Description : Three-stage pipelined multiply-accumulate with valid-qualified
//                input, global stall, optional saturation, sticky overflow and
//                an accumulate-and-dump mode driven by a sample counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module macc_pipe_dump #(
  parameter int A_WIDTH  = 8,
  parameter int B_WIDTH  = 8,
  parameter int Z_WIDTH  = 24,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0,
  parameter int DUMP_LEN = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  output logic [Z_WIDTH-1:0] Z,
  output logic               out_valid,
  output logic               ovf
);

  localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int CNT_WIDTH = (DUMP_LEN > 0) ? $clog2(DUMP_LEN + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] DUMP_CNT = CNT_WIDTH'(DUMP_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Reject configurations the accumulator cannot represent.
  if (Z_WIDTH < P_WIDTH) begin : g_bad_z_width
    $error("macc_pipe_dump: Z_WIDTH must be >= A_WIDTH+B_WIDTH");
  end
  if (DUMP_LEN < 0 || DUMP_LEN > 65535) begin : g_bad_dump_len
    $error("macc_pipe_dump: DUMP_LEN must be in 0..65535");
  end

  // Stage 1 registers
  logic [A_WIDTH-1:0] s1_a;
  logic [B_WIDTH-1:0] s1_b;
  logic               s1_valid;
  logic               s1_clr;

  // Stage 2 registers
  logic [P_WIDTH-1:0] s2_p;
  logic               s2_valid;
  logic               s2_clr;

  // Stage 3 state besides Z/ovf/out_valid
  logic [CNT_WIDTH-1:0] count;

  // Operands extended to product width; the low P_WIDTH bits of the product of
  // sign-extended operands equal the two's-complement product.
  logic               a_fill;
  logic               b_fill;
  logic [P_WIDTH-1:0] a_ext;
  logic [P_WIDTH-1:0] b_ext;
  logic [P_WIDTH-1:0] prod;

  assign a_fill = (SIGNED != 0) & s1_a[A_WIDTH-1];
  assign b_fill = (SIGNED != 0) & s1_b[B_WIDTH-1];
  assign a_ext  = {{B_WIDTH{a_fill}}, s1_a};
  assign b_ext  = {{A_WIDTH{b_fill}}, s1_b};
  assign prod   = a_ext * b_ext;

  // Product extended to accumulator width.
  logic [Z_WIDTH-1:0] p_ext;
  if (Z_WIDTH > P_WIDTH) begin : g_ext_wide
    logic p_fill;
    assign p_fill = (SIGNED != 0) & s2_p[P_WIDTH-1];
    assign p_ext  = {{(Z_WIDTH-P_WIDTH){p_fill}}, s2_p};
  end else begin : g_ext_same
    assign p_ext = s2_p;
  end

  // Accumulator adder with overflow detection and optional clamp.
  logic [Z_WIDTH:0]   sum_full;
  logic [Z_WIDTH-1:0] sum;
  logic               carry_ovf;
  logic               signed_ovf;
  logic               add_ovf;
  logic [Z_WIDTH-1:0] sat_val;
  logic [Z_WIDTH-1:0] acc_next;

  assign sum_full   = {1'b0, Z} + {1'b0, p_ext};
  assign sum        = sum_full[Z_WIDTH-1:0];
  assign carry_ovf  = sum_full[Z_WIDTH];
  assign signed_ovf = (Z[Z_WIDTH-1] == p_ext[Z_WIDTH-1]) &&
                      (sum[Z_WIDTH-1] != Z[Z_WIDTH-1]);
  assign add_ovf    = (SIGNED != 0) ? signed_ovf : carry_ovf;

  // Signed overflow direction follows the sign of the addend.
  assign sat_val  = (SIGNED == 0)       ? {Z_WIDTH{1'b1}} :
                    p_ext[Z_WIDTH-1]    ? {1'b1, {(Z_WIDTH-1){1'b0}}} :
                                          {1'b0, {(Z_WIDTH-1){1'b1}}};
  assign acc_next = ((SATURATE != 0) && add_ovf) ? sat_val : sum;

  // A completed dump makes the next valid sample start a fresh accumulation.
  logic                 dump_hit;
  logic                 restart;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 done_next;

  assign dump_hit   = (DUMP_LEN != 0) && (count == DUMP_CNT);
  assign restart    = s2_clr | dump_hit;
  assign count_next = restart ? CNT_ONE : count + CNT_ONE;
  assign done_next  = (DUMP_LEN == 0) || (count_next == DUMP_CNT);

  // Stage 1: capture operands and their qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_valid <= 1'b0;
      s1_clr   <= 1'b0;
    end else if (ena) begin
      s1_a     <= A;
      s1_b     <= B;
      s1_valid <= in_valid;
      s1_clr   <= clr;
    end
  end

  // Stage 2: register the product, carrying valid and clr alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_p     <= '0;
      s2_valid <= 1'b0;
      s2_clr   <= 1'b0;
    end else if (ena) begin
      s2_p     <= prod;
      s2_valid <= s1_valid;
      s2_clr   <= s1_clr;
    end
  end

  // Stage 3: accumulate, clear, or hold; flag results and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z         <= '0;
      ovf       <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (ena) begin
      if (s2_valid) begin
        if (restart) begin
          Z   <= p_ext;
          ovf <= 1'b0;
        end else begin
          Z   <= acc_next;
          ovf <= ovf | add_ovf;
        end
        count     <= count_next;
        out_valid <= done_next;
      end else begin
        if (s2_clr) begin
          Z     <= '0;
          ovf   <= 1'b0;
          count <= '0;
        end
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_macc_pipe_dump.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_macc_pipe_dump
//  Description : Self-checking bench for macc_pipe_dump; several configurations
//                share one stimulus stream and are checked against an
//                arithmetic reference model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_macc_pipe_dump;

  localparam int NDUT = 6;

  function automatic int zw_of(int i);
    return (i < 2) ? 24 : 16;
  endfunction
  function automatic int sg_of(int i);
    return (i == 2 || i == 4) ? 1 : 0;
  endfunction
  function automatic int sat_of(int i);
    return (i == 2 || i == 5) ? 1 : 0;
  endfunction
  function automatic int dl_of(int i);
    case (i)
      1:       return 4;
      4:       return 3;
      5:       return 1;
      default: return 0;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic [NDUT-1:0][23:0] zz;
  logic [NDUT-1:0]       ovl;
  logic [NDUT-1:0]       ovfl;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int ZW = zw_of(g);
    logic [ZW-1:0] z;
    macc_pipe_dump #(
      .A_WIDTH(8), .B_WIDTH(8), .Z_WIDTH(ZW),
      .SIGNED(sg_of(g)), .SATURATE(sat_of(g)), .DUMP_LEN(dl_of(g))
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid),
      .A(a), .B(b), .Z(z), .out_valid(ovl[g]), .ovf(ovfl[g])
    );
    assign zz[g] = 24'(z);
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit       c;
    bit       v;
    bit [7:0] a;
    bit [7:0] b;
  } smp_t;

  smp_t   q[$];
  longint acc[NDUT];
  bit     m_ov[NDUT];
  bit     m_ovf[NDUT];
  int     cnt[NDUT];

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    smp_t bub;
    bub = '{c: 1'b0, v: 1'b0, a: 8'd0, b: 8'd0};
    q.delete();
    q.push_back(bub);
    q.push_back(bub);
    for (int i = 0; i < NDUT; i++) begin
      acc[i] = 0; m_ov[i] = 0; m_ovf[i] = 0; cnt[i] = 0;
    end
  endtask

  // One sample reaching the accumulator of every configuration.
  task automatic model_apply(input smp_t e);
    for (int i = 0; i < NDUT; i++) begin
      longint p, s, lo, hi, span;
      int     dl;
      dl   = dl_of(i);
      span = longint'(1) << zw_of(i);
      if (sg_of(i) != 0) begin
        p  = longint'($signed(e.a)) * longint'($signed(e.b));
        hi = span / 2 - 1;
        lo = -(span / 2);
      end else begin
        p  = longint'(e.a) * longint'(e.b);
        hi = span - 1;
        lo = 0;
      end
      if (!e.v) begin
        if (e.c) begin
          acc[i] = 0; m_ovf[i] = 0; cnt[i] = 0;
        end
        m_ov[i] = 0;
      end else begin
        if (e.c || (dl > 0 && cnt[i] == dl)) begin
          acc[i] = p; m_ovf[i] = 0; cnt[i] = 1;
        end else begin
          s = acc[i] + p;
          if (s > hi || s < lo) begin
            m_ovf[i] = 1;
            if (sat_of(i) != 0) acc[i] = (s > hi) ? hi : lo;
            else                acc[i] = (s > hi) ? s - span : s + span;
          end else begin
            acc[i] = s;
          end
          cnt[i]++;
        end
        m_ov[i] = (dl == 0) || (cnt[i] == dl);
      end
    end
  endtask

  // Called right after a rising edge, while the inputs it saw are still driven.
  task automatic model_edge();
    smp_t e, cur;
    if (!rst_n || !ena) return;
    e   = q.pop_front();
    model_apply(e);
    cur = '{c: clr, v: in_valid, a: a, b: b};
    q.push_back(cur);
  endtask

  task automatic step(input bit en, input bit c, input bit v, input bit [7:0] aa, input bit [7:0] bb);
    ena = en; clr = c; in_valid = v; a = aa; b = bb;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NDUT; i++) begin
        logic [63:0] mask;
        mask = (64'd1 << zw_of(i)) - 64'd1;
        check($sformatf("z[%0d]", i), 64'(zz[i]) & mask, 64'(acc[i]) & mask);
        check($sformatf("out_valid[%0d]", i), 64'(ovl[i]), 64'(m_ov[i]));
        check($sformatf("ovf[%0d]", i), 64'(ovfl[i]), 64'(m_ovf[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit [7:0] dv[5];
    dv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd2};

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("reset_z", 64'(zz[0]), 64'd0);
    check("reset_out_valid", 64'(ovl[0]), 64'd0);
    check("reset_ovf", 64'(ovfl[0]), 64'd0);
    rst_n = 1'b1;

    // Three samples of 3*4 accumulate to 12, 24, 36.
    for (int i = 0; i < 6; i++) begin
      step(1, 0, i < 3, 8'd3, 8'd4);
      if (i >= 2 && i <= 4) begin
        check("basic_z", 64'(zz[0]), 64'(12 * (i - 1)));
        check("basic_out_valid", 64'(ovl[0]), 64'd1);
      end
    end
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Dump of four samples: 1+4+9+16 = 30, then a fresh start at 4.
    for (int i = 0; i < 8; i++) begin
      step(1, 0, i < 5, (i < 5) ? dv[i] : 8'd0, (i < 5) ? dv[i] : 8'd0);
      if (i == 5) begin
        check("dump_z", 64'(zz[1]), 64'd30);
        check("dump_out_valid", 64'(ovl[1]), 64'd1);
      end
      if (i == 6) begin
        check("dump_restart_z", 64'(zz[1]), 64'd4);
        check("dump_restart_out_valid", 64'(ovl[1]), 64'd0);
      end
    end

    // Signed saturation: (-128)^2 twice clamps to 32767, clr then -1.
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       step(1, 1, 1, 8'h80, 8'h80);
        1:       step(1, 0, 1, 8'h80, 8'h80);
        2:       step(1, 1, 1, 8'h01, 8'hFF);
        default: step(1, 0, 0, 8'h00, 8'h00);
      endcase
      if (i == 2) check("sat_first_z", 64'(zz[2]), 64'd16384);
      if (i == 3) begin
        check("sat_clamp_z", 64'(zz[2]), 64'd32767);
        check("sat_ovf", 64'(ovfl[2]), 64'd1);
      end
      if (i == 4) begin
        check("sat_clr_z", 64'(zz[2]), 64'hFFFF);
        check("sat_clr_ovf", 64'(ovfl[2]), 64'd0);
      end
    end

    // Unsigned wrap, then asynchronous reset with two samples in flight.
    step(1, 1, 1, 8'hFF, 8'hFF);
    step(1, 0, 1, 8'hFF, 8'hFF);
    step(1, 0, 1, 8'd7, 8'd7);
    check("wrap_first_z", 64'(zz[3]), 64'd65025);
    step(1, 0, 1, 8'd7, 8'd7);
    check("wrap_z", 64'(zz[3]), 64'd64514);
    check("wrap_ovf", 64'(ovfl[3]), 64'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_z", 64'(zz[3]), 64'd0);
    check("async_rst_ovf", 64'(ovfl[3]), 64'd0);
    check("async_rst_out_valid", 64'(ovl[3]), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step(1, 0, 0, 0, 0);
    check("async_flushed_z", 64'(zz[3]), 64'd0);

    // Stall and bubble: four valid 5*5 samples sum to 100.
    step(1, 1, 1, 8'd5, 8'd5);
    step(1, 0, 1, 8'd5, 8'd5);
    step(0, 0, 1, 8'd9, 8'd9);
    step(0, 0, 1, 8'd9, 8'd9);
    step(1, 0, 1, 8'd5, 8'd5);
    step(1, 0, 0, 8'd5, 8'd5);
    step(1, 0, 1, 8'd5, 8'd5);
    repeat (3) step(1, 0, 0, 0, 0);
    check("stall_sum_z", 64'(zz[0]), 64'd100);

    // Randomized traffic with stalls, clears, extremes and occasional resets.
    for (int n = 0; n < 2500; n++) begin
      bit [7:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hFF : 8'h80)
                                       : 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hFF : 8'h7F)
                                       : 8'($urandom_range(0, 255));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, ra, rb);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end
    repeat (4) step(1, 0, 0, 0, 0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
